// File: rtl/bit_dereverse.sv
// bit_dereverse
//   Reorders an FFT output stream from bit-reversed frame order into natural
//   frame order using a ping-pong buffer: one bank fills with the incoming
//   frame while the other bank drains. Each output frame is marked by a
//   start-of-frame pulse coincident with output index 0.
//
// Parameters
//   DATA_W : width of one sample word (I and Q concatenated by the user)
//   DEPTH  : frame length in samples, power of 2 and >= 4
//
// Ports
//   mclk      in   clock, rising edge
//   i_init    in   synchronous active-high reset
//   i_vld     in   input sample valid (no backpressure)
//   i_data    in   input sample, bit-reversed frame order
//   o_vld     out  output sample valid
//   o_new_fft out  pulses with output index 0 of each frame
//   o_data    out  output sample, natural frame order (holds when o_vld = 0)
//
// Configuration
//   BIT_DEREVERSE_CHECK_EN : when defined, compiles in simulation-only checks
//   (DEPTH power of 2, frame completing before the previous readout's last
//   cycle, o_new_fft without o_vld). Behaviour and ports are unchanged.

module bit_dereverse #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              mclk,
  input  logic              i_init,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic              o_new_fft,
  output logic [DATA_W-1:0] o_data
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Two banks, addressed as {bank, offset}; never reset.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [AW-1:0]     wr_cnt_q,    wr_cnt_d;
  logic              wr_bank_q,   wr_bank_d;
  logic              rd_active_q, rd_active_d;
  logic [AW-1:0]     rd_cnt_q,    rd_cnt_d;
  logic              rd_bank_q,   rd_bank_d;
  logic              o_vld_q,     o_vld_d;
  logic              o_new_fft_q, o_new_fft_d;
  logic [DATA_W-1:0] o_data_q,    o_data_d;

  logic              wr_en;
  logic              frame_done;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    wr_en      = i_vld && !i_init;
    frame_done = wr_en && (wr_cnt_q == LAST);
    rd_word    = mem[{rd_bank_q, bitrev(rd_cnt_q)}];
  end

  always_ff @(posedge mclk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_cnt_q}] <= i_data;
    end
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_active_d = rd_active_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    o_vld_d     = 1'b0;
    o_new_fft_d = 1'b0;
    o_data_d    = o_data_q;

    if (i_vld) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      if (frame_done) begin
        wr_bank_d = ~wr_bank_q;
      end
    end

    if (rd_active_q) begin
      o_vld_d     = 1'b1;
      o_new_fft_d = (rd_cnt_q == '0);
      o_data_d    = rd_word;
      rd_cnt_d    = rd_cnt_q + AW'(1);
      if (rd_cnt_q == LAST) begin
        rd_active_d = 1'b0;
      end
    end

    // A completing frame overrides the end of the current readout, so a
    // completion in the readout's last cycle continues output seamlessly.
    if (frame_done) begin
      rd_active_d = 1'b1;
      rd_cnt_d    = '0;
      rd_bank_d   = wr_bank_q;
    end
  end

  always_ff @(posedge mclk) begin
    if (i_init) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      o_vld_q     <= 1'b0;
      o_new_fft_q <= 1'b0;
      o_data_q    <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_active_q <= rd_active_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      o_vld_q     <= o_vld_d;
      o_new_fft_q <= o_new_fft_d;
      o_data_q    <= o_data_d;
    end
  end

  assign o_vld     = o_vld_q;
  assign o_new_fft = o_new_fft_q;
  assign o_data    = o_data_q;

`ifdef BIT_DEREVERSE_CHECK_EN
  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_depth_chk
    $fatal(1, "bit_dereverse: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
  end

  always_ff @(posedge mclk) begin
    if (frame_done && rd_active_q && (rd_cnt_q != LAST)) begin
      $fatal(1, "bit_dereverse: frame completed while readout at %0d of %0d",
             rd_cnt_q, DEPTH);
    end
    if (o_new_fft_q && !o_vld_q) begin
      $fatal(1, "bit_dereverse: o_new_fft asserted without o_vld");
    end
  end
`endif

endmodule

// File: tb/tb_bit_dereverse.sv
// tb_bit_dereverse
//   Self-checking bench for bit_dereverse at DEPTH=8, DATA_W=8. A table of
//   per-cycle {inputs, expected outputs} rows covers reset, a single frame,
//   stale-sample discard on reset, and i_vld ignored during reset. Hand-written
//   sequences cover back-to-back frames, reset mid-readout, reset in the
//   readout's last cycle and random-duty input checked against a reorder model.

module tb_bit_dereverse;

  localparam int unsigned DW = 8;
  localparam int unsigned D  = 8;

  logic          mclk = 1'b0;
  logic          i_init;
  logic          i_vld;
  logic [DW-1:0] i_data;
  logic          o_vld;
  logic          o_new_fft;
  logic [DW-1:0] o_data;

  bit_dereverse #(.DATA_W(DW), .DEPTH(D)) dut (
    .mclk      (mclk),
    .i_init    (i_init),
    .i_vld     (i_vld),
    .i_data    (i_data),
    .o_vld     (o_vld),
    .o_new_fft (o_new_fft),
    .o_data    (o_data)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic       init;
    logic       vld;
    logic [7:0] din;
    logic       ev;
    logic       en;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic row(input logic init, input logic vld, input int din,
                     input logic ev, input logic en, input int ed);
    vec_t v;
    v.init = init; v.vld = vld; v.din = 8'(din);
    v.ev = ev; v.en = en; v.ed = 8'(ed);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] fin [3][8];
  int         sent, got;

  initial begin
    i_init = 1'b1; i_vld = 1'b0; i_data = '0;

    // Reset, then one frame in bit-reversed order -> 0..7 out.
    row(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) row(0, 1, brv[n], 0, 0, 0);
    for (int k = 0; k < 8; k++) row(0, 0, 0, 1, k == 0, k);
    row(0, 0, 0, 0, 0, 7);
    row(0, 0, 0, 0, 0, 7);
    // Five stale samples, reset with i_vld high (ignored), then a full frame.
    for (int n = 0; n < 5; n++) row(0, 1, 8'hA0 + n, 0, 0, 7);
    row(1, 1, 8'hEE, 0, 0, 0);
    for (int n = 0; n < 8; n++) row(0, 1, 8'h10 | brv[n], 0, 0, 0);
    for (int k = 0; k < 8; k++) row(0, 0, 0, 1, k == 0, 8'h10 + k);
    row(0, 0, 0, 0, 0, 8'h17);

    for (int i = 0; i < tbl.size(); i++) begin
      i_init = tbl[i].init; i_vld = tbl[i].vld; i_data = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_vld", i), o_vld,     tbl[i].ev);
      chk($sformatf("tbl%0d_sof", i), o_new_fft, tbl[i].en);
      chk($sformatf("tbl%0d_dat", i), o_data,    tbl[i].ed);
    end
    i_init = 1'b0; i_vld = 1'b0;

    // Four back-to-back frames: continuous 32-cycle output.
    for (int c = 0; c < 42; c++) begin
      int m;
      logic ev;
      i_vld  = (c < 32);
      i_data = 8'(((c / 8) * 16) + brv[c % 8]);
      tick();
      m  = c - 8;
      ev = (c >= 8) && (c < 40);
      chk("b2b_vld", o_vld, ev);
      chk("b2b_sof", o_new_fft, ev && (m % 8 == 0));
      if (ev) chk("b2b_dat", o_data, 8'(((m / 8) * 16) + (m % 8)));
    end

    // Reset at output index 3.
    for (int n = 0; n < 8; n++) begin
      i_vld = 1'b1; i_data = 8'(8'h30 | brv[n]); tick();
    end
    i_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_dat", o_data, 8'h30 + k);
    end
    i_init = 1'b1; tick(); i_init = 1'b0;
    chk("mid_rst_vld", o_vld, 0);
    chk("mid_rst_dat", o_data, 0);
    chk("mid_rst_sof", o_new_fft, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mid_quiet", o_vld, 0);
    end

    // Reset during the readout's last cycle.
    for (int n = 0; n < 8; n++) begin
      i_vld = 1'b1; i_data = 8'(8'h40 | brv[n]); tick();
    end
    i_vld = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("last_pre_dat", o_data, 8'h46);
    i_init = 1'b1; tick(); i_init = 1'b0;
    chk("last_rst_vld", o_vld, 0);
    chk("last_rst_dat", o_data, 0);
    // Seven samples: not a full frame, so nothing must come out.
    for (int n = 0; n < 7; n++) begin
      i_vld = 1'b1; i_data = 8'(8'h50 | brv[n]); tick();
      chk("part_vld", o_vld, 0);
    end
    i_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("part_idle", o_vld, 0);
    end
    i_vld = 1'b1; i_data = 8'(8'h50 | brv[7]); tick(); i_vld = 1'b0;
    chk("part_done_vld", o_vld, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("part_out_dat", o_data, 8'h50 + k);
      chk("part_out_sof", o_new_fft, k == 0);
    end
    tick();
    chk("part_end_vld", o_vld, 0);

    // Random 30% duty, three frames, checked against the reorder model.
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 8; j++) fin[f][j] = 8'($urandom_range(0, 255));
    sent = 0; got = 0;
    for (int c = 0; c < 400 && got < 24; c++) begin
      if (sent < 24 && $urandom_range(0, 9) < 3) begin
        i_vld = 1'b1; i_data = fin[sent / 8][sent % 8]; sent++;
      end else begin
        i_vld = 1'b0;
      end
      tick();
      if (o_vld) begin
        chk("rnd_dat", o_data, fin[got / 8][brv[got % 8]]);
        chk("rnd_sof", o_new_fft, (got % 8) == 0);
        got++;
      end else if (got % 8 != 0) begin
        chk("rnd_burst", o_vld, 1);
      end
    end
    i_vld = 1'b0;
    chk("rnd_count", got, 24);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
